// File: rtl/config_frame_writer.sv
// rtl/config_frame_writer.sv - frame-latch configuration writer for one tile column
// Accepts a header plus N frame words and strobes each word into its latch with setup/hold guards.
module config_frame_writer #(
  parameter int         MaxFramesPerCol = 20,
  parameter int         FrameBitsPerRow = 32,
  parameter int         NumColumns      = 16,
  parameter logic [7:0] SyncByte        = 8'hFA
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic [FrameBitsPerRow-1:0]    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [FrameBitsPerRow-1:0]    FrameData,
  output logic [MaxFramesPerCol-1:0]    FrameStrobe,
  output logic [$clog2(NumColumns)-1:0] col_sel,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int CW   = $clog2(MaxFramesPerCol + 1);
  localparam int ColW = $clog2(NumColumns);

  typedef enum logic [2:0] {IDLE, DWAIT, SETUP, STROB, HOLD} state_e;

  state_e                       state_q;
  logic [FrameBitsPerRow-1:0]   data_q;
  logic [MaxFramesPerCol-1:0]   strobe_q;
  logic [ColW-1:0]              col_q;
  logic [CW-1:0]                n_q;
  logic [CW-1:0]                k_q;
  logic                         done_q;
  logic                         err_q;

  logic [7:0]  hdr_sync;
  logic [7:0]  hdr_col;
  logic [15:0] hdr_n;
  logic        hdr_ok;
  logic        xfer;
  logic        k_last;

  assign hdr_sync = s_data[31:24];
  assign hdr_col  = s_data[23:16];
  assign hdr_n    = s_data[15:0];
  assign hdr_ok   = (hdr_sync == SyncByte) && (hdr_n != 16'd0) &&
                    (hdr_n <= 16'(MaxFramesPerCol)) &&
                    ({8'd0, hdr_col} < 16'(NumColumns));

  // Gated by resetn so the loader sees no acceptance while the writer is held in reset.
  assign s_ready = resetn && ((state_q == IDLE) || (state_q == DWAIT));
  assign xfer    = s_valid && s_ready;
  assign k_last  = (k_q == n_q - CW'(1));

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      data_q   <= '0;
      strobe_q <= '0;
      col_q    <= '0;
      n_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (hdr_ok) begin
              col_q   <= hdr_col[ColW-1:0];
              n_q     <= hdr_n[CW-1:0];
              k_q     <= '0;
              state_q <= DWAIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DWAIT: begin
          if (xfer) begin
            data_q  <= s_data;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          strobe_q <= MaxFramesPerCol'(1) << k_q;
          state_q  <= STROB;
        end
        STROB: begin
          strobe_q <= '0;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (k_last) begin
            k_q     <= '0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            k_q     <= k_q + CW'(1);
            state_q <= DWAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign col_sel     = col_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// tb/tb_config_frame_writer.sv - directed self-checking bench for config_frame_writer
module tb_config_frame_writer;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic [3:0]  col_sel;
  logic        busy, done, err;

  config_frame_writer dut (
    .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .col_sel(col_sel),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [19:0] sq_s[$];
  logic [31:0] sq_d[$];
  int          sq_c[$];
  logic [31:0] fd_prev = '0;
  logic [31:0] fd_at = '0;
  bit          pend = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-cycle watcher: one-hot strobe, data stable around each strobe, pulse counting.
  always @(negedge CLK) begin
    cyc++;
    check("onehot", 64'($countones(FrameStrobe) <= 1), 64'd1);
    check("done_err_excl", 64'(done & err), 64'd0);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (pend && resetn) begin
      check("hold_data", 64'(FrameData), 64'(fd_at));
      check("strobe_width", 64'(FrameStrobe), 64'd0);
    end
    pend = 0;
    if (FrameStrobe != '0) begin
      check("setup_data", 64'(FrameData), 64'(fd_prev));
      sq_s.push_back(FrameStrobe);
      sq_d.push_back(FrameData);
      sq_c.push_back(cyc);
      fd_at = FrameData;
      pend = 1;
    end
    fd_prev = FrameData;
  end

  task automatic clear_q();
    sq_s.delete(); sq_d.delete(); sq_c.delete();
  endtask

  // Called at a negedge; returns at the negedge following the transferring posedge.
  task automatic send(input logic [31:0] w);
    int t = 0;
    s_data = w;
    s_valid = 1'b1;
    while (!s_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 100) check("send_timeout", 64'd0, 64'd1);
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int lim);
    int t = 0;
    while (done_cnt <= base && t < lim) begin
      @(negedge CLK);
      t++;
    end
    if (done_cnt <= base) check("done_timeout", 64'd0, 64'd1);
  endtask

  logic [31:0] rej[4];
  int b_done, b_err;

  initial begin
    rej[0] = 32'hAB00_0001; rej[1] = 32'hFA00_0000;
    rej[2] = 32'hFA00_0015; rej[3] = 32'hFA10_0001;

    repeat (2) @(negedge CLK);
    check("rst_FrameData", 64'(FrameData), 64'd0);
    check("rst_FrameStrobe", 64'(FrameStrobe), 64'd0);
    check("rst_col_sel", 64'(col_sel), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    resetn = 1'b1;
    @(negedge CLK);
    check("idle_s_ready", 64'(s_ready), 64'd1);

    // Two frames into column 3, valid held high
    clear_q();
    b_done = done_cnt;
    send(32'hFA03_0002);
    check("a_busy", 64'(busy), 64'd1);
    check("a_col_sel", 64'(col_sel), 64'd3);
    send(32'hDEAD_BEEF);
    send(32'h1234_5678);
    wait_done(b_done, 50);
    check("a_nstrobes", 64'(sq_s.size()), 64'd2);
    if (sq_s.size() == 2) begin
      check("a_strobe0", 64'(sq_s[0]), 64'h00001);
      check("a_data0", 64'(sq_d[0]), 64'hDEADBEEF);
      check("a_strobe1", 64'(sq_s[1]), 64'h00002);
      check("a_data1", 64'(sq_d[1]), 64'h12345678);
    end
    check("a_done_once", 64'(done_cnt - b_done), 64'd1);
    check("a_busy_low", 64'(busy), 64'd0);
    check("a_col_kept", 64'(col_sel), 64'd3);
    check("a_data_kept", 64'(FrameData), 64'h12345678);

    // Full column of 20 frames
    clear_q();
    b_done = done_cnt;
    send(32'hFA00_0014);
    for (int i = 0; i < 20; i++) send(32'h1000_0000 + 32'(i));
    wait_done(b_done, 50);
    check("b_nstrobes", 64'(sq_s.size()), 64'd20);
    if (sq_s.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        check("b_strobe", 64'(sq_s[i]), 64'(20'd1 << i));
        check("b_data", 64'(sq_d[i]), 64'(32'h1000_0000 + 32'(i)));
        if (i > 0) check("b_spacing", 64'(sq_c[i] - sq_c[i-1]), 64'd4);
      end
    end
    check("b_done_once", 64'(done_cnt - b_done), 64'd1);
    check("b_col_sel", 64'(col_sel), 64'd0);

    // Rejected headers
    for (int r = 0; r < 4; r++) begin
      clear_q();
      b_done = done_cnt;
      b_err = err_cnt;
      send(rej[r]);
      repeat (2) @(negedge CLK);
      check("rej_err", 64'(err_cnt - b_err), 64'd1);
      check("rej_busy", 64'(busy), 64'd0);
      check("rej_nostrobe", 64'(sq_s.size()), 64'd0);
      check("rej_nodone", 64'(done_cnt - b_done), 64'd0);
      check("rej_col_kept", 64'(col_sel), 64'd0);
      check("rej_data_kept", 64'(FrameData), 64'h1000_0013);
    end

    // Loader stalls for 10 cycles between frames
    clear_q();
    b_done = done_cnt;
    send(32'hFA05_0003);
    send(32'hAAAA_0000);
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      check("stall_s_ready", 64'(s_ready), 64'd1);
      check("stall_strobe", 64'(FrameStrobe), 64'd0);
      check("stall_data", 64'(FrameData), 64'hAAAA_0000);
      @(negedge CLK);
    end
    send(32'hAAAA_0001);
    send(32'hAAAA_0002);
    wait_done(b_done, 50);
    check("c_nstrobes", 64'(sq_s.size()), 64'd3);
    if (sq_s.size() == 3) begin
      check("c_strobe2", 64'(sq_s[2]), 64'h00004);
      check("c_data1", 64'(sq_d[1]), 64'hAAAA_0001);
      check("c_data2", 64'(sq_d[2]), 64'hAAAA_0002);
    end
    check("c_col_sel", 64'(col_sel), 64'd5);
    check("c_done_once", 64'(done_cnt - b_done), 64'd1);

    // Asynchronous reset during the strobe of frame 1
    clear_q();
    send(32'hFA07_0003);
    send(32'hBBBB_0000);
    send(32'hBBBB_0001);
    @(posedge CLK);
    #2;
    check("d_in_strobe", 64'(FrameStrobe), 64'h00002);
    b_done = done_cnt;
    resetn = 1'b0;
    #1;
    check("d_rst_strobe", 64'(FrameStrobe), 64'd0);
    check("d_rst_data", 64'(FrameData), 64'd0);
    check("d_rst_col", 64'(col_sel), 64'd0);
    check("d_rst_busy", 64'(busy), 64'd0);
    check("d_rst_ready", 64'(s_ready), 64'd0);
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    repeat (5) @(negedge CLK);
    check("d_no_done", 64'(done_cnt - b_done), 64'd0);
    check("d_idle", 64'(busy), 64'd0);
    clear_q();
    send(32'hFA01_0001);
    send(32'h55AA_55AA);
    wait_done(b_done, 50);
    check("e_col_sel", 64'(col_sel), 64'd1);
    check("e_nstrobes", 64'(sq_s.size()), 64'd1);
    if (sq_s.size() == 1) begin
      check("e_strobe", 64'(sq_s[0]), 64'h00001);
      check("e_data", 64'(sq_d[0]), 64'h55AA_55AA);
    end
    check("e_done_once", 64'(done_cnt - b_done), 64'd1);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Drives the frame-latch configuration interface of one tile column: FrameData plus a one-hot FrameStrobe.
- Consumes a valid/ready word stream from the bitstream loader: one header word, then N frame words.
- Each frame word is presented on FrameData with setup and hold guard cycles around a single-cycle strobe, so transparent latches capture it cleanly on strobe fall.
- Sits between the config loader and the per-column FrameData/FrameStrobe distribution.

Parameters:
- MaxFramesPerCol, 20, width of FrameStrobe; maximum frames per column.
- FrameBitsPerRow, 32, width of FrameData and s_data; must be >= 32.
- NumColumns, 16, number of addressable columns; col_sel width is clog2(NumColumns).
- SyncByte, 8'hFA, required value of header bits [31:24].

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- s_data  in  FrameBitsPerRow  stream word (header or frame data).
- s_valid  in  1  s_data valid.
- s_ready  out  1  writer accepts s_data this cycle.
- FrameData  out  FrameBitsPerRow  data to the frame latches.
- FrameStrobe  out  MaxFramesPerCol  one-hot latch enable.
- col_sel  out  clog2(NumColumns)  column being written.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last frame's HOLD cycle.
- err  out  1  one-cycle pulse on a rejected header.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; FrameData=0, FrameStrobe=0, col_sel=0.
  - busy=0, done=0, err=0, s_ready=0; frame index k=0, count N=0.
- Transfer rule: a word transfers on a rising edge with s_valid&s_ready. s_ready is combinational from state: 1 only in IDLE and DWAIT.
- Header format:
  - [31:24] sync; [23:16] column; [15:0] frame count N.
  - Extra bits above 31 are ignored.
- IDLE: on header transfer:
  - Reject if sync!=SyncByte, N==0, N>MaxFramesPerCol, or column>=NumColumns. On reject: err=1 next cycle, stay IDLE, no output change.
  - Otherwise latch col_sel=column, N, k=0, and go to DWAIT.
- DWAIT: on transfer, register FrameData=s_data and go to SETUP.
- SETUP: one cycle; FrameStrobe=0, FrameData stable. Go to STROB.
- STROB: one cycle; FrameStrobe=one-hot bit k, all other bits 0. Go to HOLD.
- HOLD: one cycle; FrameStrobe=0, FrameData unchanged.
  - If k==N-1: go to IDLE, done=1 for one cycle, k=0.
  - Else: k=k+1, go to DWAIT.
- Invariants:
  - FrameStrobe never has more than one bit set.
  - FrameStrobe is high only in STROB.
  - FrameData changes only on a DWAIT transfer, so it is never changing while any strobe is high.
- Throughput: 4 cycles per frame minimum (DWAIT accept, SETUP, STROB, HOLD); no back-to-back strobes.
- FrameData and col_sel retain their last values in IDLE; they are not cleared after done.
- s_valid low in DWAIT: wait indefinitely; outputs hold.
- s_valid is ignored in SETUP/STROB/HOLD (s_ready=0).
- Frame ordering: frame k always uses strobe bit k, k=0..N-1. The index wraps to 0 only via IDLE.
- Reset mid-operation, including during STROB: FrameStrobe drops to 0 asynchronously. Remaining frames are abandoned and done is not pulsed. Latches keep whatever was captured.
- done and err are registered and never asserted in the same cycle.

Test Plan:
- Reset, then header 32'hFA03_0002, frames 32'hDEAD_BEEF and 32'h1234_5678 with s_valid always high:
  - col_sel=3.
  - FrameStrobe=20'h00001 for exactly one cycle with FrameData=32'hDEADBEEF stable in the cycles before and after.
  - Then 20'h00002 with 32'h12345678.
  - done pulses once, busy falls.
- Header 32'hFA00_0014 (N=20), frames 0..19:
  - Strobe walks bit0..bit19, each one-hot and one cycle wide.
  - Spacing between strobes is exactly 4 cycles.
  - done after the 20th HOLD.
- Rejects, each with no strobe and state staying IDLE:
  - 32'hAB00_0001 (bad sync) -> err pulse.
  - 32'hFA00_0000 (N=0) -> err pulse.
  - 32'hFA00_0015 (N=21) -> err pulse.
  - 32'hFA10_0001 (column 16) -> err pulse.
- Header N=3, then hold s_valid=0 for 10 cycles before frame 1:
  - s_ready=1 throughout, FrameStrobe=0, FrameData holds frame 0's value.
  - Completion is still correct afterwards.
- Assert resetn=0 during STROB of frame 1 of N=3:
  - FrameStrobe=0 immediately (asynchronously), all outputs at reset values, no done.
  - After release, a new header is accepted normally.
- Throughout all tests (checker): popcount(FrameStrobe)<=1 every cycle, and FrameData equal in the cycles before, during and after each strobe.
